// File: rtl/somasub_pkg.sv
// Shared types and op encoding for the digit-serial add/subtract unit.
package somasub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SAT = 2'b10;

  localparam int OP_SUB_BIT = 0;
  localparam int OP_SAT_BIT = 1;

endpackage

// File: rtl/somasub_digit.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit
// so the caller can derive signed overflow on the final slice.
module somasub_digit #(
  parameter int DIGIT = 2
) (
  input  logic             cin,
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic c;
    c     = cin;
    sum   = '0;
    c_msb = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/somasub_serial.sv
// Digit-serial add/subtract with optional signed saturation; one DIGIT slice
// per cycle, result and flags published only when the last slice completes.
module somasub_serial
  import somasub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             sign
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh_p0;
  logic [WIDTH-1:0]   b_sh_p0;
  logic [WIDTH-1:0]   acc_p0;
  logic               cin_p0;
  logic [1:0]         op_p0;
  logic               a_msb_p0;

  logic [DIGIT-1:0]   d_sum;
  logic               d_cout;
  logic               d_cmsb;
  logic [WIDTH-1:0]   sum_full;
  logic               ovf_fin;
  logic               carry_fin;
  logic signed [WIDTH-1:0] r_fin;
  logic               start_ok;

  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] raw,
    input logic                    v,
    input logic                    sat,
    input logic                    neg
  );
    logic signed [WIDTH-1:0] lim;
    lim = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return (sat && v) ? lim : raw;
  endfunction

  somasub_digit #(.DIGIT(DIGIT)) u_digit (
    .cin   (cin_p0),
    .x     (a_sh_p0[DIGIT-1:0]),
    .y     (b_sh_p0[DIGIT-1:0]),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // New slice enters at the top; after STEPS shifts the LSB slice sits at bit 0.
  assign sum_full  = WIDTH'({d_sum, acc_p0} >> DIGIT);
  assign ovf_fin   = d_cmsb ^ d_cout;
  assign carry_fin = op_p0[OP_SUB_BIT] ? ~d_cout : d_cout;
  assign r_fin     = saturate($signed(sum_full), ovf_fin, op_p0[OP_SAT_BIT], a_msb_p0);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));

  // Operand capture and slice shifting
  always_ff @(posedge clk) begin
    if (start_ok) begin
      a_sh_p0  <= a;
      b_sh_p0  <= op[OP_SUB_BIT] ? ~b : b;
      cin_p0   <= op[OP_SUB_BIT];
      op_p0    <= op;
      a_msb_p0 <= a[WIDTH-1];
    end else if (state == BUSY) begin
      a_sh_p0 <= a_sh_p0 >> DIGIT;
      b_sh_p0 <= b_sh_p0 >> DIGIT;
      acc_p0  <= sum_full;
      cin_p0  <= d_cout;
    end
  end

  // Control FSM and published result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      r     <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      sign  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= BUSY;
            busy  <= 1'b1;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(STEPS - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            r     <= r_fin;
            carry <= carry_fin;
            ovf   <= ovf_fin;
            zero  <= (r_fin == '0);
            sign  <= r_fin[WIDTH-1];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_somasub_serial.sv
// Directed and randomized checks of somasub_serial in three configurations.
module tb_somasub_serial;
  import somasub_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  st = '0;
  logic [1:0]  op = '0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;

  logic        busy8, done8, c8, v8, z8, s8;
  logic [7:0]  r8;
  logic        busy16, done16, c16, v16, z16, s16;
  logic [15:0] r16;
  logic        busy88, done88, c88, v88, z88, s88;
  logic [7:0]  r88;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  somasub_serial #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .op(op), .a(a_in[7:0]), .b(b_in[7:0]),
    .busy(busy8), .done(done8), .r(r8), .carry(c8), .ovf(v8), .zero(z8), .sign(s8));

  somasub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .op(op), .a(a_in), .b(b_in),
    .busy(busy16), .done(done16), .r(r16), .carry(c16), .ovf(v16), .zero(z16), .sign(s16));

  somasub_serial #(.WIDTH(8), .DIGIT(8)) dut88 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .op(op), .a(a_in[7:0]), .b(b_in[7:0]),
    .busy(busy88), .done(done88), .r(r88), .carry(c88), .ovf(v88), .zero(z88), .sign(s88));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic dn(input int sel);
    case (sel)
      0:       return done8;
      1:       return done16;
      default: return done88;
    endcase
  endfunction

  // {r zero-extended to 16, carry, ovf, zero, sign}
  function automatic logic [19:0] res(input int sel);
    case (sel)
      0:       return {8'h00, r8, c8, v8, z8, s8};
      1:       return {r16, c16, v16, z16, s16};
      default: return {8'h00, r88, c88, v88, z88, s88};
    endcase
  endfunction

  function automatic logic [19:0] model(input int w, input logic [1:0] o,
                                        input logic [15:0] x_in, input logic [15:0] y_in);
    logic [16:0] s;
    logic [15:0] mask, x, y, rr, lim;
    logic c, v, am, bm, rm;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    x = x_in & mask;
    y = y_in & mask;
    if (o[0]) begin
      s = {1'b0, x} - {1'b0, y};
      c = (x < y);
    end else begin
      s = {1'b0, x} + {1'b0, y};
      c = (w == 16) ? s[16] : s[8];
    end
    rr = s[15:0] & mask;
    am = x[w-1];
    bm = y[w-1];
    rm = rr[w-1];
    v  = o[0] ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
    lim = 16'h1 << (w - 1);
    if (o[1] && v) rr = am ? lim : (lim - 16'h1);
    return {rr, c, v, (rr == 16'h0), rr[w-1]};
  endfunction

  task automatic do_op(input int sel, input logic [1:0] o, input logic [15:0] x,
                       input logic [15:0] y, output int lat);
    op = o;
    a_in = x;
    b_in = y;
    st[sel] = 1'b1;
    tick();
    st[sel] = 1'b0;
    lat = 0;
    while (!dn(sel) && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int k;
    int dcount;
    logic [1:0]  ro;
    logic [15:0] rx, ry;

    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {busy8, done8, res(0)}, 22'h0);
    tick();
    tick();
    rst_n = 1'b1;

    do_op(0, OP_ADD, 16'h7F, 16'h01, lat);
    check("add_7f_01_latency", lat, 4);
    check("add_7f_01_result", res(0), {16'h0080, 4'b0101});
    check("busy_done_exclusive", {busy8, done8}, 2'b01);

    do_op(0, OP_SUB, 16'h05, 16'h07, lat);
    check("sub_05_07", res(0), {16'h00FE, 4'b1001});

    do_op(0, OP_SUB, 16'h30, 16'h30, lat);
    check("sub_30_30", res(0), {16'h0000, 4'b0010});

    do_op(0, OP_SAT | OP_ADD, 16'h7F, 16'h01, lat);
    check("sat_add_7f_01", res(0), {16'h007F, 4'b0100});

    do_op(0, OP_SAT | OP_SUB, 16'h80, 16'h01, lat);
    check("sat_sub_80_01", res(0), {16'h0080, 4'b0101});

    do_op(0, OP_SAT | OP_ADD, 16'h10, 16'h20, lat);
    check("sat_add_10_20", res(0), {16'h0030, 4'b0000});

    // start pulsed mid-operation with different operands
    op = OP_ADD; a_in = 16'h11; b_in = 16'h22; st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    tick();
    k = 1;
    op = OP_SUB; a_in = 16'hFF; b_in = 16'hFF; st[0] = 1'b1;
    tick();
    k++;
    st[0] = 1'b0;
    while (!done8 && k < 20) begin
      tick();
      k++;
    end
    check("ignore_start_latency", k, 4);
    check("ignore_start_result", res(0), {16'h0033, 4'b0000});

    // start held high while in DONE
    op = OP_ADD; a_in = 16'h01; b_in = 16'h02; st[0] = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!done8 && k < 20);
    st[0] = 1'b0;
    check("back_to_back_period", k, 5);
    check("back_to_back_result", res(0), {16'h0003, 4'b0000});
    tick();

    // reset asserted mid-operation
    op = OP_ADD; a_in = 16'h7F; b_in = 16'h01; st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("reset_mid_busy_outputs", {busy8, done8, res(0)}, 22'h0);
    tick();
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done8 || busy8) dcount++;
    end
    check("no_done_after_abort", dcount, 0);

    // first start right after release
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    do_op(0, OP_ADD, 16'h01, 16'h01, lat);
    check("start_after_release_latency", lat, 4);
    check("start_after_release_result", res(0), {16'h0002, 4'b0000});

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      ry = 16'($urandom);
      do_op(1, ro, rx, ry, lat);
      check("w16_latency", lat, 4);
      check("w16_result", res(1), model(16, ro, rx, ry));
    end

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom) & 16'h00FF;
      ry = 16'($urandom) & 16'h00FF;
      do_op(2, ro, rx, ry, lat);
      check("w8d8_latency", lat, 1);
      check("w8d8_result", res(2), model(8, ro, rx, ry));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
